// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel frame deserializer with sync marker
// Optional even-parity bit per frame when DESERIALIZER_PARITY_EN is defined.
module deserializer #(
  parameter int MSB_FIRST = 1,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DESERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             start;
  logic             abort;
  logic             shift_en;
  logic             last_bit;
  logic             done;

  // The first received bit ends up at the top for MSB_FIRST, at bit 0 otherwise.
  function automatic logic [WIDTH-1:0] push(input logic [WIDTH-1:0] base, input logic b);
    if (MSB_FIRST != 0) return {base[WIDTH-2:0], b};
    else                return {b, base[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = SHIFT;
`ifdef DESERIALIZER_PARITY_EN
      SHIFT: if (last_bit) state_next = PARITY;
      PARITY: begin
        if (abort)     state_next = SHIFT;
        else if (done) state_next = IDLE;
      end
`else
      SHIFT: if (last_bit) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // A premature sync both aborts the current frame and starts the next one.
  always_comb begin
    start    = 1'b0;
    abort    = 1'b0;
    shift_en = 1'b0;
    last_bit = 1'b0;
    done     = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: start = in_sync;
        SHIFT: begin
          abort    = in_sync;
          start    = in_sync;
          shift_en = !in_sync;
          last_bit = !in_sync && (cnt == LAST);
        end
`ifdef DESERIALIZER_PARITY_EN
        PARITY: begin
          abort = in_sync;
          start = in_sync;
          done  = !in_sync;
        end
`endif
        default: ;
      endcase
    end
`ifndef DESERIALIZER_PARITY_EN
    done = last_bit;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      hold      <= '0;
      out_value <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      out_valid <= done;
      frame_err <= abort;
      if (start) begin
        hold <= push('0, in_bit);
        cnt  <= CW'(1);
      end else if (shift_en) begin
        hold <= push(hold, in_bit);
        cnt  <= cnt + CW'(1);
      end
      if (done) begin
        cnt <= '0;
`ifdef DESERIALIZER_PARITY_EN
        out_value  <= hold;
        parity_err <= (^hold) ^ in_bit;
`else
        out_value <= push(hold, in_bit);
`endif
      end
    end
  end

`ifndef DESERIALIZER_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - scoreboard and vector-table bench for deserializer
module tb_deserializer;

`ifdef DESERIALIZER_PARITY_EN
  localparam int MSB = 0;
  localparam bit PAR = 1'b1;
`else
  localparam int MSB = 1;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sync = 1'b0;
  logic [7:0] out_value;
  logic       out_valid;
  logic       frame_err;
  logic       parity_err;

  deserializer #(.MSB_FIRST(MSB), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sync(in_sync),
    .out_value(out_value), .out_valid(out_valid), .frame_err(frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] value;
    logic       perr;
  } exp_t;

  typedef struct packed {
    logic [7:0] value;
    logic [3:0] gap;
  } vec_t;

  exp_t sb[$];
  int   vt[$];
  int   exp_ferr = 0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    else pass_cnt++;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && frame_err) check("valid_and_ferr_exclusive", 1, 0);
    if (out_valid) begin
      vt.push_back(cyc);
      if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("out_value", {24'd0, out_value}, {24'd0, e.value});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
      end
    end
    if (frame_err) begin
      if (exp_ferr == 0) check("unexpected_frame_err", 1, 0);
      else begin
        exp_ferr--;
        check("frame_err_pulse", {31'd0, frame_err}, 1);
      end
    end
  end

  task automatic drive(input logic b, input logic s);
    @(negedge clk);
    in_bit = b; in_sync = s; in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_sync = 1'b0;
    end
  endtask

  function automatic logic bit_at(input logic [7:0] v, input int i);
    return (MSB != 0) ? v[7-i] : v[i];
  endfunction

  task automatic send_frame(input logic [7:0] v, input int gap, input logic flip);
    for (int i = 0; i < 8; i++) begin
      drive(bit_at(v, i), i == 0);
      if (i < 7 && gap > 0) idle(gap);
    end
    if (PAR) begin
      if (gap > 0) idle(gap);
      drive((^v) ^ flip, 1'b0);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && (sb.size() != 0 || exp_ferr != 0); i++) @(negedge clk);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_ferr_done"}, exp_ferr, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hA5, 4'd0};
    vecs[1] = '{8'hA5, 4'd3};
    vecs[2] = '{8'h00, 4'd1};
    vecs[3] = '{8'hFF, 4'd0};
    vecs[4] = '{8'h3C, 4'd2};
    vecs[5] = '{8'h81, 4'd0};
    vecs[6] = '{8'h5A, 4'd1};

    rst = 1'b1;
    #3;
    check("reset_out_value", {24'd0, out_value}, 0);
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    check("reset_parity_err", {31'd0, parity_err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef DESERIALIZER_PARITY_EN
    sb.push_back('{8'h07, 1'b0});
    send_frame(8'h07, 0, 1'b0);
    idle(1);
    check("parity_latency", {31'd0, out_valid}, 1);
    sb.push_back('{8'h07, 1'b1});
    send_frame(8'h07, 0, 1'b1);
    idle(1);
    check("parity_bad_latency", {31'd0, out_valid}, 1);
    drain("parity");
`else
    // first frame after reset, zero latency
    sb.push_back('{8'hA5, 1'b0});
    send_frame(8'hA5, 0, 1'b0);
    idle(1);
    check("latency_out_valid", {31'd0, out_valid}, 1);
    idle(1);
    check("out_valid_one_cycle", {31'd0, out_valid}, 0);
    drain("first");

    for (int k = 0; k < 7; k++) begin
      sb.push_back('{vecs[k].value, 1'b0});
      send_frame(vecs[k].value, int'(vecs[k].gap), 1'b0);
      idle(2);
    end
    drain("table");

    // bits without sync in IDLE are discarded
    drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
    idle(3);
    check("idle_discard_hold", {24'd0, out_value}, 32'h5A);

    // back-to-back frames
    vt.delete();
    sb.push_back('{8'h3C, 1'b0});
    sb.push_back('{8'hFF, 1'b0});
    send_frame(8'h3C, 0, 1'b0);
    send_frame(8'hFF, 0, 1'b0);
    idle(3);
    drain("b2b");
    check("b2b_pulse_count", vt.size(), 2);
    if (vt.size() >= 2) check("b2b_spacing", vt[1] - vt[0], 8);

    // premature sync on bit 5, then 0x81 completes
    for (int i = 0; i < 5; i++) drive(bit_at(8'h66, i), i == 0);
    exp_ferr++;
    sb.push_back('{8'h81, 1'b0});
    drive(bit_at(8'h81, 0), 1'b1);
    drive(bit_at(8'h81, 1), 1'b0);
    check("abort_ferr_timing", {31'd0, frame_err}, 1);
    check("abort_hold_value", {24'd0, out_value}, 32'hFF);
    for (int i = 2; i < 8; i++) drive(bit_at(8'h81, i), 1'b0);
    idle(1);
    check("abort_final_value", {24'd0, out_value}, 32'h81);
    drain("abort");

    // async reset mid-frame
    for (int i = 0; i < 4; i++) drive(bit_at(8'hC3, i), i == 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_value", {24'd0, out_value}, 0);
    check("async_rst_valid", {31'd0, out_valid}, 0);
    repeat (3) @(negedge clk);
    check("rst_no_pulse", {31'd0, out_valid | frame_err}, 0);
    rst = 1'b0;
    sb.push_back('{8'h5A, 1'b0});
    send_frame(8'h5A, 0, 1'b0);
    idle(2);
    drain("post_rst");
    check("post_rst_value", {24'd0, out_value}, 32'h5A);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter MSB_FIRST, default 1, meaning 1 = first received bit is out_value[7], 0 = first received bit is out_value[0].
REQ-002 Parameter WIDTH, default 8, meaning data bits per frame; legal range 2..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_bit  input  1  serial data bit, sampled only when in_valid=1.
REQ-006 in_valid  input  1  bit strobe; one bit is consumed per cycle with in_valid=1.
REQ-007 in_sync  input  1  frame marker; qualified by in_valid; marks the first bit of a frame.
REQ-008 out_value  output  WIDTH  last completed frame; holds until the next completion.
REQ-009 out_valid  output  1  one-cycle pulse when out_value updates.
REQ-010 frame_err  output  1  one-cycle pulse on an aborted frame.
REQ-011 parity_err  output  1  parity mismatch flag, valid with out_valid; constant 0 when parity is compiled out.

Function
REQ-012 The FSM SHALL have states IDLE and SHIFT, plus PARITY when DESERIALIZER_PARITY_EN is defined.
REQ-013 IDLE: in_valid=1 with in_sync=1 SHALL capture in_bit as data bit 0, set bit counter to 1, and go to SHIFT.
REQ-014 IDLE: in_valid=1 with in_sync=0 SHALL discard the bit, with no output change.
REQ-015 SHIFT: each in_valid=1 with in_sync=0 SHALL shift in_bit into the holding register and increment the counter.
REQ-016 SHIFT: in_valid=0 cycles SHALL hold all state; stall length is unbounded.
REQ-017 On the edge sampling data bit WIDTH-1, the block SHALL perform all of the following:
  - load out_value from the holding register plus the final bit;
  - set out_valid=1 for exactly the following cycle;
  - go to IDLE (or to PARITY when compiled in).
REQ-018 Latency SHALL be 0 cycles: out_valid is high in the cycle immediately after the final data bit's sampling edge.
REQ-019 Bit order SHALL follow MSB_FIRST; MSB_FIRST=1 with bit sequence 1,0,1,0,0,1,0,1 yields 0xA5.
REQ-020 SHIFT or PARITY receiving in_valid=1 with in_sync=1 (premature sync) SHALL perform all of the following:
  - pulse frame_err for one cycle;
  - leave out_value unchanged and out_valid low;
  - treat the current bit as data bit 0 of a new frame, with counter=1 and state SHIFT.
REQ-021 Back-to-back frames SHALL be accepted: a sync bit in the cycle right after the final bit starts the next frame with no dead cycle.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL clear to 0 on every return to IDLE; it never wraps.
REQ-023 out_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-024 rst=1 SHALL immediately force all of the following, independent of clk:
  - state=IDLE, counter=0, holding register=0;
  - out_value=0, out_valid=0, frame_err=0, parity_err=0.
REQ-025 Reset mid-frame SHALL discard the partial frame with no out_valid and no frame_err.
REQ-026 The first in_sync bit after rst deasserts SHALL start a frame normally.

Configuration
REQ-027 Macro DESERIALIZER_PARITY_EN, when defined:
  - frame = WIDTH data bits + 1 even-parity bit;
  - the PARITY state consumes the parity bit;
  - out_value, out_valid and parity_err update on the parity bit's edge;
  - parity_err=1 when XOR of data and parity bits is 1;
  - out_value is delivered regardless of parity_err.
REQ-028 Macro undefined: no PARITY state, frame is WIDTH bits, parity_err tied 0.

Verification
REQ-029 rst pulse, then 8 strobed bits 1,0,1,0,0,1,0,1 (sync on first) -> out_value=0xA5, out_valid high 1 cycle after 8th bit edge, frame_err=0.
REQ-030 Same frame with in_valid=0 gaps of 3 cycles between bits -> out_value=0xA5, single out_valid pulse.
REQ-031 Frames 0x3C then 0xFF back-to-back, no gap -> two out_valid pulses 8 strobes apart, values 0x3C then 0xFF.
REQ-032 Sync on bit 5 of a frame, then 7 more bits completing 0x81 -> frame_err pulse at bit 5, then out_value=0x81, previous out_value held until then.
REQ-033 rst asserted asynchronously after 4 bits, then new frame 0x5A -> outputs 0 during reset, no pulses, then out_value=0x5A.
REQ-034 DESERIALIZER_PARITY_EN defined with MSB_FIRST=0 -> both cases give out_value=0x07:
  - bits 1,1,1,0,0,0,0,0 plus parity 1 -> parity_err=0;
  - bits 1,1,1,0,0,0,0,0 plus parity 0 -> parity_err=1.
